// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline.
// Provides XLEN, reset PC, NOP encoding, if_entry_t and a saturating adder.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Two-entry synchronous FIFO, head presented from a register (no bypass).
// Ports: clk, rst (async active-low), flush, push, pop, din, dout, count.
module if_fifo
  import riscv_pkg::*;
#(
  parameter type T = if_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  T           din,
  output T           dout,
  output logic [1:0] count
);

  T     e0;
  T     e1;
  logic do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign dout   = e0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // Credit accounting upstream makes a push into a full FIFO impossible.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !flush && count == 2'd2 && !do_pop)
  );

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues imem requests, buffers 2 responses.
// Ports: clk/rst, imem_req_*, imem_rsp_*, redirect_*, if_* to decode;
// with IF_PERF_CNT_EN defined also perf_fetched / perf_dropped.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  logic [XLEN-1:0] pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic [1:0]      fifo_cnt;
  logic [1:0]      tag_cnt;
  logic [2:0]      used;
  logic            accept;
  logic            pop;
  logic            push;
  logic            drop_rsp;
  logic [XLEN-1:0] tag_pc;
  if_entry_t       head;
  if_entry_t       push_entry;

  // A pop this cycle frees a slot for the request issued this cycle,
  // which is what sustains one instruction per cycle.
  assign pop = if_valid && if_ready && !redirect_valid;
  assign used = {1'b0, outstanding} + {1'b0, fifo_cnt} - {2'b0, pop};

  assign imem_req_valid = rst && !redirect_valid && (used < 3'd2);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop_rsp = imem_rsp_valid && (redirect_valid || drop_cnt != 2'd0);
  assign push     = imem_rsp_valid && !drop_rsp;

  assign push_entry = '{pc: tag_pc, inst: imem_rsp_data};

  assign if_valid = (fifo_cnt != 2'd0);
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;

  // PC tags follow every accepted request and retire on every response,
  // dropped or not, so they stay aligned across redirects.
  if_fifo #(.T(logic [XLEN-1:0])) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (accept),
    .pop   (imem_rsp_valid),
    .din   (pc),
    .dout  (tag_pc),
    .count (tag_cnt)
  );

  if_fifo #(.T(if_entry_t)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, imem_rsp_valid};
      if (redirect_valid) begin
        pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding - {1'b0, imem_rsp_valid};
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  a_tag_sync: assert property (
    @(posedge clk) disable iff (!rst) tag_cnt == outstanding
  );

`ifdef IF_PERF_CNT_EN
  logic [1:0] drop_inc;

  // Redirect discards the buffered entries plus any response in that cycle.
  always_comb begin
    drop_inc = '0;
    if (redirect_valid) drop_inc = fifo_cnt + {1'b0, imem_rsp_valid};
    else if (drop_rsp)  drop_inc = 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, {1'b0, pop});
      perf_dropped <= sat_add(perf_dropped, drop_inc);
    end
  end
`endif

endmodule
